// File: rtl/bram_responder.sv
// Block-RAM stand-in for the SDRAM request/response FIFO path: pop request, access RAM, push one response.
// Optional macro BRAM_RESPONDER_ADDR_CHECK_EN enables out-of-range detection and err_count.
module bram_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [40:0] req_data,
  input  logic        req_empty,
  output logic        req_read,
  output logic [40:0] resp_data,
  input  logic        resp_full,
  output logic        resp_write,
  output logic [7:0]  err_count,
  output logic        busy
);
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam logic [DATA_W-1:0] BAD_DATA = 16'hBAD0;

  typedef enum logic [2:0] {IDLE, POP, WAIT, MEM, RESP} state_t;

  state_t              state;
  logic [7:0]          wait_cnt;
  logic                cmd_rw;
  logic [23:0]         cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_BITS-1:0] idx;
  logic                in_range;
  logic                mem_we;

  assign idx = cmd_addr[ADDR_BITS-1:0];

`ifdef BRAM_RESPONDER_ADDR_CHECK_EN
  assign in_range = ~|cmd_addr[23:ADDR_BITS];
`else
  assign in_range = 1'b1;
`endif

  assign mem_we = (state == MEM) && cmd_rw && in_range;

  // Command registers hold the popped request; data only, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && !req_empty)
      {cmd_rw, cmd_addr, cmd_wdata} <= req_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx] <= cmd_wdata;
    if (state == MEM)
      rdata <= mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      req_read   <= 1'b0;
      resp_write <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
    end else begin
      req_read   <= 1'b0;
      resp_write <= 1'b0;
      case (state)
        IDLE: begin
          if (!req_empty) begin
            req_read <= 1'b1;
            busy     <= 1'b1;
            state    <= POP;
          end
        end
        // req_empty is ignored here so the FIFO flag can settle after the pop.
        POP: begin
          wait_cnt <= 8'(LATENCY);
          state    <= (LATENCY > 0) ? WAIT : MEM;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt <= 8'd1)
            state <= MEM;
        end
        MEM: state <= RESP;
        RESP: begin
          if (!resp_full) begin
            resp_data  <= {cmd_rw, cmd_addr,
                           cmd_rw ? cmd_wdata : (in_range ? rdata : BAD_DATA)};
            resp_write <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRAM_RESPONDER_ADDR_CHECK_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= 8'd0;
    else if (state == MEM && !in_range)
      err_count <= sat_inc(err_count);
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/bram_responder.md
# bram_responder

Block-RAM-backed responder for the 41-bit request/response FIFO protocol used by the SDRAM path. It pops requests from a request `fifo_sync`, performs the write or read against internal block RAM, and pushes one response per request into a response `fifo_sync`. It is a drop-in stand-in for `sdram` so that traffic generators and test pattern logic can be brought up without external DRAM.

## Interface
- `ADDR_BITS`, default 10: number of low address bits decoded; memory depth is 2^ADDR_BITS x 16.
- `LATENCY`, default 0: extra wait cycles inserted per request (0..255) to mimic DRAM latency.
- `clk` input, 1 bit: single clock for all logic.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `req_data` input, 41 bits: request head, formatted `{rw, addr[23:0], wdata[15:0]}`; rw=1 is write. Valid whenever `req_empty`=0 (show-ahead).
- `req_empty` input, 1 bit: request FIFO empty.
- `req_read` output, 1 bit: one-cycle pop strobe to the request FIFO.
- `resp_data` output, 41 bits: response `{rw, addr[23:0], data[15:0]}`.
- `resp_full` input, 1 bit: response FIFO full.
- `resp_write` output, 1 bit: one-cycle push strobe to the response FIFO.
- `err_count` output, 8 bits: out-of-range request count; tied 0 without the configuration macro.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- All outputs are registered. Reset values: `req_read`=0, `resp_write`=0, `resp_data`=0, `err_count`=0, `busy`=0, state=IDLE, wait counter=0. RAM contents are not reset.
- The FSM has five states: IDLE, POP, WAIT, MEM, RESP.
- IDLE: if `req_empty`=0, latch `req_data` into command registers, set `req_read`<=1, go to POP. Otherwise stay.
- POP: set `req_read`<=0 and load the wait counter with LATENCY. Go to WAIT if LATENCY>0, else go to MEM.
- WAIT: decrement the counter. Go to MEM when the counter reaches 1.
- MEM: the RAM index is `addr[ADDR_BITS-1:0]`.
  - Write: `mem[idx]<=wdata`.
  - Read: synchronous read into `rdata`.
  - Go to RESP.
- RESP: if `resp_full`=0:
  - `resp_data<={rw, addr, rw ? wdata : rdata}`.
  - `resp_write`<=1 for exactly one cycle.
  - Go to IDLE.
  - If `resp_full`=1, hold in RESP indefinitely with `resp_write`=0 and `resp_data` unchanged.
- Write responses echo the written data and serve as the "OK" acknowledgement.
- There is exactly one response per popped request, and responses are in request order.
- Address bits above ADDR_BITS alias onto the lower bits unless the configuration macro is set.
- `rst` asserted mid-operation: the FSM returns to IDLE immediately. A request already popped is dropped with no response, and a RAM write not yet performed in MEM is not performed.

## Timing
- Request visible (`req_empty`=0) at edge N:
  - `req_read` is high during cycle N+1.
  - MEM is reached at N+2+LATENCY.
  - `resp_write` is high during cycle N+4+LATENCY, provided `resp_full`=0.
- Throughput is one request per 4+LATENCY cycles with back-to-back requests: `resp_write` and the next `req_read` decision overlap in IDLE.
- `req_empty` is not sampled during POP. This gives the FIFO flag its one-cycle update after the pop.
- A read in the cycle after a write to the same index returns the new data: the write completes in MEM before the next request's MEM.

## Configuration
- `BRAM_RESPONDER_ADDR_CHECK_EN` defined: a request with any of `addr[23:ADDR_BITS]` nonzero is out of range.
  - An out-of-range write leaves RAM unmodified.
  - An out-of-range read returns data 16'hBAD0.
  - `err_count` increments once per such request in MEM and saturates at 8'hFF.
  - The response is still issued.
- Macro undefined: no check; addresses alias modulo 2^ADDR_BITS; `err_count` is constant 0.

## Test plan
- Reset, then write {1, 24'h000005, 16'h1234}, then read {0, 24'h000005, 0}: the responses are {1, 24'h000005, 16'h1234} followed by {0, 24'h000005, 16'h1234}.
- LATENCY=3 with a single request pushed at edge N: `req_read` is high at N+1 and `resp_write` is high at N+7, each for exactly one cycle.
- `resp_full` held at 1 for 20 cycles during RESP: no push and no further `req_read`; on release, exactly one push with unchanged `resp_data`.
- Write 1024 addresses with data=addr[15:0], then read all back: every read matches, with no gaps or duplicates in the response stream.
- With `BRAM_RESPONDER_ADDR_CHECK_EN` and ADDR_BITS=10: write to 24'h000400, then read 24'h000400 returns 16'hBAD0; read of 24'h000000 returns its prior value; `err_count`=2.
- `rst` asserted during WAIT (LATENCY=5): no `resp_write`; outputs return to their reset values; the next request is serviced normally.
